// File: rtl/vx_dcache_req_arb.sv
// Data-cache request arbiter: grants one requester bundle at a time into a one-entry output register
// whose lanes retire independently. Define DCACHE_ARB_RR_EN for round-robin, else fixed priority.
module vx_dcache_req_arb #(
  parameter  int NUM_INPUTS    = 4,
  parameter  int NUM_REQS      = 4,
  parameter  int WORD_SIZE     = 4,
  parameter  int TAG_IN_WIDTH  = 8,
  parameter  int XLEN          = 32,
  localparam int WORD_WIDTH    = 8 * WORD_SIZE,
  localparam int LSZ           = $clog2($clog2(WORD_SIZE) + 1),
  localparam int IW            = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + IW
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_INPUTS*NUM_REQS-1:0]              in_valid,
  input  logic [NUM_INPUTS*NUM_REQS-1:0]              in_rw,
  input  logic [NUM_INPUTS*NUM_REQS*WORD_SIZE-1:0]    in_byteen,
  input  logic [NUM_INPUTS*NUM_REQS*LSZ-1:0]          in_size,
  input  logic [NUM_INPUTS*NUM_REQS*XLEN-1:0]         in_addr,
  input  logic [NUM_INPUTS*NUM_REQS*WORD_WIDTH-1:0]   in_data,
  input  logic [NUM_INPUTS*NUM_REQS*TAG_IN_WIDTH-1:0] in_tag,
  output logic [NUM_INPUTS*NUM_REQS-1:0]              in_ready,
  output logic [NUM_REQS-1:0]                         out_valid,
  output logic [NUM_REQS-1:0]                         out_rw,
  output logic [NUM_REQS*WORD_SIZE-1:0]               out_byteen,
  output logic [NUM_REQS*LSZ-1:0]                     out_size,
  output logic [NUM_REQS*XLEN-1:0]                    out_addr,
  output logic [NUM_REQS*WORD_WIDTH-1:0]              out_data,
  output logic [NUM_REQS*TAG_OUT_WIDTH-1:0]           out_tag,
  input  logic [NUM_REQS-1:0]                         out_ready
);

  logic [NUM_REQS-1:0]               pending;
  logic [NUM_INPUTS-1:0]             req;
  logic                              free;
  logic                              grant_valid;
  logic [IW-1:0]                     grant_idx;
  logic                              fire;

  logic [NUM_REQS-1:0]               sel_valid;
  logic [NUM_REQS-1:0]               sel_rw;
  logic [NUM_REQS*WORD_SIZE-1:0]     sel_byteen;
  logic [NUM_REQS*LSZ-1:0]           sel_size;
  logic [NUM_REQS*XLEN-1:0]          sel_addr;
  logic [NUM_REQS*WORD_WIDTH-1:0]    sel_data;
  logic [NUM_REQS*TAG_OUT_WIDTH-1:0] sel_tag;

`ifdef DCACHE_ARB_RR_EN
  logic [IW-1:0]                     ptr;
`endif

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      req[i] = |in_valid[i*NUM_REQS +: NUM_REQS];
    end
  end

  // The register can accept a new bundle when every lane still pending retires this cycle.
  assign free = ~|(pending & ~out_ready);

  // Scanning from the far end down lets the nearest requester to the search start win last.
  always_comb begin
    int j;
    j           = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
`ifdef DCACHE_ARB_RR_EN
      j = int'(ptr) + k;
      if (j >= NUM_INPUTS) j = j - NUM_INPUTS;
`else
      j = k;
`endif
      if (req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(j);
      end
    end
  end

  assign fire = free & grant_valid & ~reset;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_ready[i*NUM_REQS +: NUM_REQS] = {NUM_REQS{fire && (grant_idx == IW'(i))}};
    end
  end

  // The winning index rides in the low bits of every lane's tag so responses can be routed back.
  always_comb begin
    sel_valid  = '0;
    sel_rw     = '0;
    sel_byteen = '0;
    sel_size   = '0;
    sel_addr   = '0;
    sel_data   = '0;
    sel_tag    = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_idx == IW'(i)) begin
        sel_valid  = in_valid[i*NUM_REQS +: NUM_REQS];
        sel_rw     = in_rw[i*NUM_REQS +: NUM_REQS];
        sel_byteen = in_byteen[i*NUM_REQS*WORD_SIZE +: NUM_REQS*WORD_SIZE];
        sel_size   = in_size[i*NUM_REQS*LSZ +: NUM_REQS*LSZ];
        sel_addr   = in_addr[i*NUM_REQS*XLEN +: NUM_REQS*XLEN];
        sel_data   = in_data[i*NUM_REQS*WORD_WIDTH +: NUM_REQS*WORD_WIDTH];
        for (int l = 0; l < NUM_REQS; l++) begin
          sel_tag[l*TAG_OUT_WIDTH +: TAG_OUT_WIDTH] =
            {in_tag[(i*NUM_REQS+l)*TAG_IN_WIDTH +: TAG_IN_WIDTH], grant_idx};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
`ifdef DCACHE_ARB_RR_EN
      ptr     <= '0;
`endif
    end else if (fire) begin
      pending <= sel_valid;
`ifdef DCACHE_ARB_RR_EN
      ptr     <= (grant_idx == IW'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
`endif
    end else begin
      pending <= pending & ~out_ready;
    end
  end

  // Payload needs no reset; it is only meaningful under a pending lane.
  always_ff @(posedge clk) begin
    if (fire) begin
      out_rw     <= sel_rw;
      out_byteen <= sel_byteen;
      out_size   <= sel_size;
      out_addr   <= sel_addr;
      out_data   <= sel_data;
      out_tag    <= sel_tag;
    end
  end

  assign out_valid = pending;

endmodule

// File: tb/tb_vx_dcache_req_arb.sv
// Scoreboard bench for vx_dcache_req_arb: a behavioural arbiter model queues each expected grant
// and the held bundle is compared every cycle it is pending.
module tb_vx_dcache_req_arb;
  localparam int NI = 4, NR = 4, WS = 4, TW = 8, XL = 32, WW = 32, LSZ = 2, IW = 2, TOW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [NI*NR-1:0]       in_valid, in_rw, in_ready;
  logic [NI*NR*WS-1:0]    in_byteen;
  logic [NI*NR*LSZ-1:0]   in_size;
  logic [NI*NR*XL-1:0]    in_addr;
  logic [NI*NR*WW-1:0]    in_data;
  logic [NI*NR*TW-1:0]    in_tag;
  logic [NR-1:0]          out_valid, out_rw, out_ready;
  logic [NR*WS-1:0]       out_byteen;
  logic [NR*LSZ-1:0]      out_size;
  logic [NR*XL-1:0]       out_addr;
  logic [NR*WW-1:0]       out_data;
  logic [NR*TOW-1:0]      out_tag;

  vx_dcache_req_arb dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_rw(in_rw), .in_byteen(in_byteen), .in_size(in_size),
    .in_addr(in_addr), .in_data(in_data), .in_tag(in_tag), .in_ready(in_ready),
    .out_valid(out_valid), .out_rw(out_rw), .out_byteen(out_byteen), .out_size(out_size),
    .out_addr(out_addr), .out_data(out_data), .out_tag(out_tag), .out_ready(out_ready)
  );

  typedef struct packed {
    logic [NR-1:0]     valid;
    logic [NR-1:0]     rw;
    logic [NR*WS-1:0]  byteen;
    logic [NR*LSZ-1:0] size;
    logic [NR*XL-1:0]  addr;
    logic [NR*WW-1:0]  data;
    logic [NR*TOW-1:0] tag;
  } bundle_t;

  bundle_t          exp_q[$];
  bundle_t          cur;
  int               checks = 0, passed = 0, failed = 0;
  logic [NR-1:0]    m_pending;
`ifdef DCACHE_ARB_RR_EN
  int               m_ptr;
`endif
  logic             fix_tag_en;
  logic [TW-1:0]    fix_tag;
  logic [NI*NR-1:0] rv;
  logic [NR-1:0]    rr;

  task automatic checkOutput(input string name, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic randomizeInputs(input logic [NI*NR-1:0] valid);
    in_valid = valid;
    in_rw    = 16'($urandom);
    for (int w = 0; w < NI*NR; w++) begin
      in_addr[w*XL +: XL]     = $urandom;
      in_data[w*WW +: WW]     = $urandom;
      in_byteen[w*WS +: WS]   = WS'($urandom);
      in_size[w*LSZ +: LSZ]   = LSZ'($urandom);
      in_tag[w*TW +: TW]      = fix_tag_en ? fix_tag : TW'($urandom);
    end
  endtask

  function automatic bundle_t bundleOf(input int g);
    bundle_t b;
    b.valid  = in_valid[g*NR +: NR];
    b.rw     = in_rw[g*NR +: NR];
    b.byteen = in_byteen[g*NR*WS +: NR*WS];
    b.size   = in_size[g*NR*LSZ +: NR*LSZ];
    b.addr   = in_addr[g*NR*XL +: NR*XL];
    b.data   = in_data[g*NR*WW +: NR*WW];
    for (int l = 0; l < NR; l++) b.tag[l*TOW +: TOW] = {in_tag[(g*NR+l)*TW +: TW], IW'(g)};
    return b;
  endfunction

  // One cycle: drive, predict the grant, check in_ready mid-cycle, then check the register after the edge.
  task automatic applyStimulus(input logic [NI*NR-1:0] valid, input logic [NR-1:0] ready);
    int               g;
    logic             free;
    logic [NI*NR-1:0] exp_ready;
    randomizeInputs(valid);
    out_ready = ready;
    @(negedge clk);
    free = (m_pending & ~ready) == '0;
    g = -1;
    for (int k = 0; k < NI; k++) begin
      int j;
`ifdef DCACHE_ARB_RR_EN
      j = (m_ptr + k) % NI;
`else
      j = k;
`endif
      if (g < 0 && valid[j*NR +: NR] != '0) g = j;
    end
    exp_ready = '0;
    if (free && g >= 0) begin
      exp_ready[g*NR +: NR] = '1;
      exp_q.push_back(bundleOf(g));
    end
    checkOutput("in_ready", in_ready, exp_ready);
    @(posedge clk);
    #1;
    if (free && g >= 0) begin
      m_pending = valid[g*NR +: NR];
`ifdef DCACHE_ARB_RR_EN
      m_ptr = (g + 1) % NI;
`endif
      cur = exp_q.pop_front();
    end else begin
      m_pending = m_pending & ~ready;
    end
    checkOutput("out_valid", out_valid, m_pending);
    if (m_pending != '0) begin
      checkOutput("out_tag", out_tag, cur.tag);
      checkOutput("out_addr", out_addr, cur.addr);
      checkOutput("out_data", out_data, cur.data);
      checkOutput("out_rw", out_rw, cur.rw);
      checkOutput("out_byteen", out_byteen, cur.byteen);
      checkOutput("out_size", out_size, cur.size);
    end
  endtask

  task automatic resetStep(input logic [NI*NR-1:0] valid);
    reset = 1'b1;
    randomizeInputs(valid);
    out_ready = '0;
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, '0);
    @(posedge clk);
    #1;
    m_pending = '0;
`ifdef DCACHE_ARB_RR_EN
    m_ptr = 0;
`endif
    exp_q.delete();
    checkOutput("reset_out_valid", out_valid, '0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fix_tag_en = 1'b0; fix_tag = '0; out_ready = '0; m_pending = '0;
`ifdef DCACHE_ARB_RR_EN
    m_ptr = 0;
`endif
    randomizeInputs('0);
    resetStep(16'h000F);
    resetStep(16'h000F);

    // First grant right after reset.
    applyStimulus(16'h000F, 4'hF);
    checkOutput("first_grant_idx", out_tag[1:0], 2'd0);

    // Single bundle from input 1 with a known tag.
    fix_tag_en = 1'b1; fix_tag = 8'h5A;
    applyStimulus(16'h00B0, 4'hF);
    fix_tag_en = 1'b0;
    checkOutput("tag_valid", out_valid, 4'b1011);
    checkOutput("tag_lane0", out_tag[9:0], {8'h5A, 2'd1});
    checkOutput("tag_lane3", out_tag[39:30], {8'h5A, 2'd1});

    // Partial acceptance blocks new grants until the last lane retires.
    applyStimulus(16'h0F00, 4'hF);
    applyStimulus(16'h000F, 4'b0011);
    checkOutput("partial_pending", out_valid, 4'b1100);
    applyStimulus(16'h000F, 4'b1100);
    checkOutput("partial_reload", out_valid, 4'b1111);
    checkOutput("partial_reload_idx", out_tag[1:0], 2'd0);

    // Out-of-order lane retirement with no new requests.
    applyStimulus(16'h0000, 4'b0100);
    applyStimulus(16'h0000, 4'b0001);
    applyStimulus(16'h0000, 4'b0000);
    applyStimulus(16'h0000, 4'b1010);
    checkOutput("drained", out_valid, 4'b0000);
    applyStimulus(16'h0000, 4'hF);

`ifdef DCACHE_ARB_RR_EN
    // Pointer is 1 here, so inputs 0 and 2 alternate starting with 2.
    for (int n = 0; n < 6; n++) begin
      applyStimulus(16'h0F0F, 4'hF);
      checkOutput("rr_alternate", out_tag[1:0], (n % 2 == 0) ? 2'd2 : 2'd0);
    end
    applyStimulus(16'h0F00, 4'hF);
    applyStimulus(16'hF000, 4'hF);
    checkOutput("rr_grant3", out_tag[1:0], 2'd3);
    applyStimulus(16'h00FF, 4'hF);
    checkOutput("rr_wrap0", out_tag[1:0], 2'd0);
`else
    for (int n = 0; n < 6; n++) begin
      applyStimulus(16'hF0F0, 4'hF);
      checkOutput("fixed_starve", out_tag[1:0], 2'd1);
    end
    applyStimulus(16'hF000, 4'hF);
    checkOutput("fixed_grant3", out_tag[1:0], 2'd3);
`endif

    // Reset discards a partially held bundle and restarts arbitration at input 0.
    applyStimulus(16'h0060, 4'hF);
    checkOutput("pre_reset_pending", out_valid, 4'b0110);
    resetStep(16'h00F0);
    applyStimulus(16'h0F0F, 4'hF);
    checkOutput("post_reset_idx", out_tag[1:0], 2'd0);

    for (int n = 0; n < 60; n++) begin
      rv = '0;
      for (int i = 0; i < NI; i++) if ($urandom_range(1, 0) == 1) rv[i*NR +: NR] = NR'($urandom);
      rr = ($urandom_range(2, 0) == 0) ? 4'hF : NR'($urandom);
      applyStimulus(rv, rr);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
